oai221_vector_sequencer: RTL
============================

# oai221_vector_sequencer

Self-checking sequencer that drives a 5-input OAI221 cell (ZN = !((B1|B2)&(C1|C2)&A)) through all 32 input vectors. For each vector it waits a programmable settle time, samples ZN, compares it against the built-in expected value, and accumulates mismatch results. It sits between a test controller (START/ABORT, result readback) and the cell under test. It replaces open-loop truth-table printing with an on-chip pass/fail verdict.

## Interface
- SETTLE, 2: cycles each vector is held before ZN is sampled; legal range 1..15.
- CK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset; asynchronous, active-high.
- START  in  1  begin a sweep; honoured only in IDLE or FINISH.
- ABORT  in  1  synchronous abort of a running sweep.
- ZN  in  1  output of the cell under test.
- A, B1, B2, C1, C2  out  1 each  vector drive to the cell under test.
- BUSY  out  1  high while a sweep is running.
- DONE  out  1  sweep complete; held high until the next accepted START, ABORT or RST.
- PASS  out  1  DONE & (ERR_CNT == 0).
- ERR_CNT  out  6  number of mismatching vectors, range 0..32.
- FAIL_SEEN  out  1  at least one mismatch recorded in this sweep.
- FIRST_FAIL  out  5  index of the first mismatching vector; valid when FAIL_SEEN=1.

## Operation
- Vector index idx[4:0] maps to {A,B1,B2,C1,C2}; idx=0 gives 00000 and idx=31 gives 11111. The sweep runs in ascending order.
- Expected value: exp = !((B1|B2)&(C1|C2)&A), computed from idx.
- States:
  - IDLE: vector outputs 0, BUSY=0. START moves to WAIT with idx=0 and settle count=0, and clears ERR_CNT, FAIL_SEEN, FIRST_FAIL and DONE.
  - WAIT: drive vector idx and increment the settle count. At count == SETTLE-1, move to CHECK.
  - CHECK: drive vector idx and sample ZN. If ZN != exp, increment ERR_CNT; if FAIL_SEEN=0, also set FAIL_SEEN=1 and FIRST_FAIL=idx. Then:
    - if idx==31, go to FINISH;
    - otherwise idx+1, settle count=0, go to WAIT.
  - FINISH: DONE=1, BUSY=0, vector outputs 0, results held. START restarts exactly as from IDLE.
- BUSY=1 in WAIT and CHECK. START is ignored while BUSY.
- ABORT in WAIT or CHECK goes to IDLE: DONE=0, vector outputs 0. ERR_CNT, FAIL_SEEN and FIRST_FAIL hold their partial values.
- ABORT in IDLE or FINISH has no effect.
- ABORT and START asserted together: ABORT wins if BUSY, otherwise START is accepted.
- ERR_CNT never exceeds 32, so no saturation logic is needed.
- ZN is compared as sampled. X/Z handling is the bench's concern only.

## Timing
- Reset values: state IDLE; A, B1, B2, C1, C2, BUSY, DONE and PASS = 0; ERR_CNT=0; FAIL_SEEN=0; FIRST_FAIL=0.
- RST asserted mid-sweep returns every output to its reset value immediately, without waiting for a clock edge.
- All outputs are registered. The vector outputs come straight from flops, glitch-free.
- Edge numbering: START is sampled high at edge k.
  - Vector 0 appears after edge k.
  - Each vector is held SETTLE+1 cycles. ZN for vector n is sampled at edge k + (n+1)·(SETTLE+1).
  - The next vector appears after that same edge.
- DONE, PASS and the final ERR_CNT are visible after edge k + 32·(SETTLE+1), which is k+96 for the default SETTLE=2. BUSY falls at the same edge.
- ERR_CNT and FIRST_FAIL update at the CHECK edge of the mismatching vector.
- ABORT sampled at edge j gives IDLE, BUSY=0 and outputs 0 after edge j.

## Test plan
- Correct OAI221 model on ZN, SETTLE=2, START pulse: DONE rises exactly 96 cycles after the START edge; ERR_CNT=0, PASS=1, FAIL_SEEN=0; vector outputs step through 00000..11111, each held 3 cycles.
- ZN tied to 1: ERR_CNT=9, FAIL_SEEN=1, FIRST_FAIL=21 (10101), PASS=0.
- ZN tied to 0: ERR_CNT=23, FIRST_FAIL=0, PASS=0.
- Inverted model (ZN = (B1|B2)&(C1|C2)&A): ERR_CNT=32, FIRST_FAIL=0.
- ABORT during CHECK of idx=5 with the correct model: IDLE and outputs 0 on the next cycle, BUSY=0, DONE=0. A START pulse applied during the earlier run was ignored. A new START then completes normally with PASS=1.
- RST pulse asserted mid-sweep at idx=12 (between clock edges): all outputs 0 before the next edge. SETTLE=1 run after reset: DONE 64 cycles after START, PASS=1.

Source files
------------

// File: rtl/oai221_vector_sequencer.sv
// Sweeps all 32 input vectors of an OAI221 cell, samples ZN after a programmable
// settle time and accumulates a pass/fail verdict with first-failure capture.
module oai221_vector_sequencer #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       CK,
    input  logic       RST,
    input  logic       START,
    input  logic       ABORT,
    input  logic       ZN,
    output logic       A,
    output logic       B1,
    output logic       B2,
    output logic       C1,
    output logic       C2,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [5:0] ERR_CNT,
    output logic       FAIL_SEEN,
    output logic [4:0] FIRST_FAIL
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CHECK,
        S_FINISH
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

    state_t     state_q, state_d;
    logic [4:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [4:0] vec_q, vec_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [5:0] err_cnt_q, err_cnt_d;
    logic       fail_seen_q, fail_seen_d;
    logic [4:0] first_fail_q, first_fail_d;
    logic       exp_zn;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        done_d       = done_q;
        err_cnt_d    = err_cnt_q;
        fail_seen_d  = fail_seen_q;
        first_fail_d = first_fail_q;
        exp_zn       = ~((idx_q[3] | idx_q[2]) & (idx_q[1] | idx_q[0]) & idx_q[4]);

        case (state_q)
            S_IDLE, S_FINISH: begin
                if (START) begin
                    state_d      = S_WAIT;
                    idx_d        = '0;
                    cnt_d        = '0;
                    done_d       = 1'b0;
                    err_cnt_d    = '0;
                    fail_seen_d  = 1'b0;
                    first_fail_d = '0;
                end
            end
            S_WAIT: begin
                if (ABORT) begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_CHECK: begin
                if (ABORT) begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                end else begin
                    if (ZN != exp_zn) begin
                        err_cnt_d = err_cnt_q + 6'd1;
                        if (!fail_seen_q) begin
                            fail_seen_d  = 1'b1;
                            first_fail_d = idx_q;
                        end
                    end
                    if (idx_q == 5'd31) begin
                        state_d = S_FINISH;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        cnt_d   = '0;
                        state_d = S_WAIT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are derived from the next state so every port is a plain flop.
        busy_d = (state_d == S_WAIT) || (state_d == S_CHECK);
        vec_d  = busy_d ? idx_d : '0;
        pass_d = done_d && (err_cnt_d == '0);
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            vec_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_cnt_q    <= '0;
            fail_seen_q  <= 1'b0;
            first_fail_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            vec_q        <= vec_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_cnt_q    <= err_cnt_d;
            fail_seen_q  <= fail_seen_d;
            first_fail_q <= first_fail_d;
        end
    end

    assign A          = vec_q[4];
    assign B1         = vec_q[3];
    assign B2         = vec_q[2];
    assign C1         = vec_q[1];
    assign C2         = vec_q[0];
    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign PASS       = pass_q;
    assign ERR_CNT    = err_cnt_q;
    assign FAIL_SEEN  = fail_seen_q;
    assign FIRST_FAIL = first_fail_q;

endmodule
